// File: rtl/serial_mod5_tx.sv
// serial_mod5_tx
// LSB-first serializer that also tracks the running value mod 5 of the
// bits already sent. A transfer is started from IDLE by a load with a
// legal length. The FSM then walks SHIFT for one cycle per bit and
// spends a single DONE cycle before returning to IDLE.
// Every output comes straight from a register.

module serial_mod5_tx #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic [4:0]       len,
    output logic             ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             done,
    output logic [2:0]       residue,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [4:0] MaxLen = 5'(WIDTH);

    state_t           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [4:0]       count_q;
    logic [2:0]       weight_q;
    logic             ready_q;
    logic             serOut_q;
    logic             serValid_q;
    logic             done_q;
    logic [2:0]       residue_q;
    logic             err_q;

    logic             lenOk_d;
    logic [3:0]       sum_d;
    logic [2:0]       residue_d;
    logic [2:0]       weight_d;
    logic [WIDTH-1:0] shift_d;

    assign ready     = ready_q;
    assign ser_out   = serOut_q;
    assign ser_valid = serValid_q;
    assign done      = done_q;
    assign residue   = residue_q;
    assign err       = err_q;

    // Next-value helpers: length legality, the mod-5 accumulation and the 2^k mod 5 weight step.
    always_comb begin
        lenOk_d   = (len != 5'd0) && (len <= MaxLen);
        // shift_q[0] is the bit currently shown on ser_out, so this adds ser_out*weight.
        // The sum is at most 4+4=8, so four bits hold it before the single subtract reduces it.
        sum_d     = {1'b0, residue_q} + (shift_q[0] ? {1'b0, weight_q} : 4'd0);
        residue_d = (sum_d >= 4'd5) ? 3'(sum_d - 4'd5) : sum_d[2:0];
        shift_d   = shift_q >> 1;
        weight_d  = 3'd1;
        case (weight_q)
            3'd1:    weight_d = 3'd2;
            3'd2:    weight_d = 3'd4;
            3'd4:    weight_d = 3'd3;
            3'd3:    weight_d = 3'd1;
            default: weight_d = 3'd1;
        endcase
    end

    // Main FSM with registered outputs. Reset wins over everything, including a simultaneous load.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            count_q    <= 5'd0;
            weight_q   <= 3'd0;
            ready_q    <= 1'b1;
            serOut_q   <= 1'b0;
            serValid_q <= 1'b0;
            done_q     <= 1'b0;
            residue_q  <= 3'd0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        if (lenOk_d) begin
                            shift_q    <= data_in;
                            count_q    <= len;
                            serOut_q   <= data_in[0];
                            serValid_q <= 1'b1;
                            residue_q  <= 3'd0;
                            weight_q   <= 3'd1;
                            ready_q    <= 1'b0;
                            state_q    <= SHIFT;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    residue_q <= residue_d;
                    weight_q  <= weight_d;
                    shift_q   <= shift_d;
                    count_q   <= count_q - 5'd1;
                    if (count_q == 5'd1) begin
                        serOut_q   <= 1'b0;
                        serValid_q <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        serOut_q <= shift_d[0];
                    end
                end
                DONE: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    serValid_q <= 1'b0;
                    serOut_q   <= 1'b0;
                    ready_q    <= 1'b1;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_mod5_tx.sv
// tb_serial_mod5_tx
// Directed vectors with hand-computed results. Each load pushes the expected
// bit stream and the final residue into a queue. An independent monitor pops
// and compares whenever the DUT shows ser_valid or done.

module tb_serial_mod5_tx;

    localparam int WIDTH = 10;

    logic             clk = 1'b0;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] data_in;
    logic [4:0]       len;
    logic             ready;
    logic             ser_out;
    logic             ser_valid;
    logic             done;
    logic [2:0]       residue;
    logic             err;

    typedef struct {
        bit         isDone;
        logic       expBit;
        logic [2:0] expRes;
    } exp_t;

    exp_t expQ[$];
    int   checks      = 0;
    int   errors      = 0;
    int   errSeen     = 0;
    int   errExpected = 0;
    bit   monitorOn   = 1'b0;
    logic prevValid   = 1'b0;

    serial_mod5_tx #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .data_in   (data_in),
        .len       (len),
        .ready     (ready),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .done      (done),
        .residue   (residue),
        .err       (err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Single comparison point; every check goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: pops one expectation per ser_valid or done cycle and flags gaps or stray output.
    always @(negedge clk) begin
        if (monitorOn) begin
            if (err === 1'b1) errSeen++;
            if (ser_valid === 1'b1 || done === 1'b1) begin
                checkOutput("valid_and_done_together", 32'(ser_valid & done), 32'd0);
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_valid_done", 32'({ser_valid, done}), 32'd0);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("output_kind", 32'({ser_valid, done}), e.isDone ? 32'd1 : 32'd2);
                    checkOutput(e.isDone ? "done_ser_out" : "ser_out", 32'(ser_out),
                                e.isDone ? 32'd0 : 32'(e.expBit));
                    checkOutput(e.isDone ? "done_residue" : "bit_residue", 32'(residue), 32'(e.expRes));
                end
            end else if (prevValid === 1'b1 && expQ.size() != 0) begin
                checkOutput("gap_in_stream", 32'(ser_valid), 32'd1);
            end
            prevValid = ser_valid;
        end
    end

    // Issue a load and queue the first nBits bits plus, for a full transfer, the done entry.
    task automatic applyStimulus(input logic [WIDTH-1:0] data, input int l, input logic [2:0] doneRes,
                                 input int nBits);
        int d;
        d = int'(data);
        for (int k = 0; k < nBits; k++) begin
            exp_t e;
            e.isDone = 1'b0;
            e.expBit = data[k];
            e.expRes = 3'((d & ((1 << k) - 1)) % 5);
            expQ.push_back(e);
        end
        if (nBits == l) begin
            exp_t e;
            e.isDone = 1'b1;
            e.expBit = 1'b0;
            e.expRes = doneRes;
            expQ.push_back(e);
        end
        @(posedge clk);
        #1;
        load    = 1'b1;
        data_in = data;
        len     = 5'(l);
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    // Illegal-length load: expect one err pulse, ready kept high, residue untouched.
    task automatic applyIllegal(input logic [4:0] l, input logic [2:0] heldRes);
        @(posedge clk);
        #1;
        load    = 1'b1;
        data_in = 10'h155;
        len     = l;
        errExpected++;
        @(posedge clk);
        #1;
        load = 1'b0;
        @(negedge clk);
        checkOutput("err_pulse", 32'(err), 32'd1);
        checkOutput("err_ready", 32'(ready), 32'd1);
        checkOutput("err_residue_held", 32'(residue), 32'(heldRes));
        @(negedge clk);
        checkOutput("err_single_cycle", 32'(err), 32'd0);
    endtask

    // Bounded wait for the queue to drain, then check the idle state.
    task automatic waitIdle(input string name, input logic [2:0] finalRes);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        checkOutput({name, "_drained"}, 32'(expQ.size()), 32'd0);
        @(negedge clk);
        checkOutput({name, "_ready"}, 32'(ready), 32'd1);
        checkOutput({name, "_residue_hold"}, 32'(residue), 32'(finalRes));
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation timed out");
        $fatal(1, "[TB] timeout");
    end

    // Directed sequence.
    initial begin
        reset   = 1'b0;
        load    = 1'b0;
        data_in = '0;
        len     = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ready", 32'(ready), 32'd1);
        checkOutput("reset_ser_valid", 32'(ser_valid), 32'd0);
        checkOutput("reset_ser_out", 32'(ser_out), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        checkOutput("reset_residue", 32'(residue), 32'd0);
        monitorOn = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;

        // 27 = 011011, len 6 -> 1,1,0,1,1,0 and residue 2
        applyStimulus(10'd27, 6, 3'd2, 6);
        @(negedge clk);
        checkOutput("busy_ready_low", 32'(ready), 32'd0);
        waitIdle("t27", 3'd2);

        // 31 len 5 -> residue 1; 858 len 10 -> residue 3
        applyStimulus(10'd31, 5, 3'd1, 5);
        waitIdle("t31", 3'd1);
        applyStimulus(10'd858, 10, 3'd3, 10);
        waitIdle("t858", 3'd3);

        // Illegal lengths: residue keeps 3
        applyIllegal(5'd0, 3'd3);
        applyIllegal(5'd11, 3'd3);

        // Load pulses during SHIFT must be ignored
        applyStimulus(10'd27, 6, 3'd2, 6);
        load    = 1'b1;
        data_in = 10'h3FF;
        len     = 5'd3;
        repeat (2) begin
            @(negedge clk);
            checkOutput("load_in_shift_err", 32'(err), 32'd0);
        end
        @(posedge clk);
        #1;
        load = 1'b0;
        waitIdle("t27_ignore", 3'd2);

        // Upper bits ignored: 0x3FF len 4 -> 15 mod 5 = 0
        applyStimulus(10'h3FF, 4, 3'd0, 4);
        waitIdle("t3ff", 3'd0);

        // Reset while bit 3 of 858/10 is on the line
        applyStimulus(10'd858, 10, 3'd3, 4);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset_ser_valid", 32'(ser_valid), 32'd0);
        checkOutput("midreset_residue", 32'(residue), 32'd0);
        checkOutput("midreset_ready", 32'(ready), 32'd1);
        checkOutput("midreset_done", 32'(done), 32'd0);
        repeat (12) @(negedge clk);
        checkOutput("midreset_queue", 32'(expQ.size()), 32'd0);
        applyStimulus(10'd858, 10, 3'd3, 10);
        waitIdle("t858_after_reset", 3'd3);

        // Reset together with a legal load: load must not be accepted
        @(posedge clk);
        #1;
        reset   = 1'b0;
        load    = 1'b1;
        data_in = 10'd27;
        len     = 5'd6;
        @(posedge clk);
        #1;
        reset = 1'b1;
        load  = 1'b0;
        @(negedge clk);
        checkOutput("reset_load_ready", 32'(ready), 32'd1);
        checkOutput("reset_load_ser_valid", 32'(ser_valid), 32'd0);
        checkOutput("reset_load_residue", 32'(residue), 32'd0);
        repeat (8) @(negedge clk);

        checkOutput("err_pulse_count", 32'(errSeen), 32'(errExpected));
        checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
